aes_capture_buffer: RTL and testbench

//   Parametrised capture harness around the pipelined aes_128 core. Registers plaintext/key
//   on a valid strobe, drives the core, tracks each request through the core's fixed latency
//   and stores results in a DEPTH-word buffer with a synchronous readback port.

---
 rtl/aes_cap_pkg.sv | 12 +
 rtl/aes_capture_buffer_ram.sv | 39 +++
 rtl/aes_capture_buffer.sv | 126 ++++++++++++
 tb/tb_aes_capture_buffer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_cap_pkg.sv
// Shared constants and types for the AES capture harness.
package aes_cap_pkg;

  localparam int unsigned AES_WIDTH      = 128;
  localparam int unsigned AES128_LATENCY = 21;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RING    = 1'b1
  } cap_mode_e;

endpackage

// File: rtl/aes_capture_buffer_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port, read-old-data.
module aes_capture_buffer_ram
  import aes_cap_pkg::*;
#(
  parameter int unsigned WIDTH = AES_WIDTH,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/aes_capture_buffer.sv
// Capture harness around a pipelined AES-128 core: registers requests, tracks them through
// the core latency with a tag shifter and stores results in a oneshot/ring readback buffer.
module aes_capture_buffer
  import aes_cap_pkg::*;
#(
  parameter int unsigned WIDTH       = AES_WIDTH,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AES_LATENCY = AES128_LATENCY,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_state_i,
  input  logic [WIDTH-1:0] in_key_i,
  output logic [WIDTH-1:0] aes_state_o,
  output logic [WIDTH-1:0] aes_key_o,
  input  logic [WIDTH-1:0] aes_out_i,
  input  logic             mode_i,
  input  logic             clear_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0]       state_q, key_q;
  logic                   vld_q;
  logic [AES_LATENCY-1:0] tag_q, tag_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_base_q, rd_base_d;
  logic [AW:0]            count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   rd_valid_q;
  logic                   capture, full, wr_en;
  logic [AW-1:0]          raddr;
  cap_mode_e              mode;

  assign mode    = cap_mode_e'(mode_i);
  assign full    = (count_q == DepthCnt);
  assign capture = tag_q[AES_LATENCY-1];
  assign raddr   = rd_base_q + rd_addr_i;

  always_comb begin
    tag_d     = {tag_q[AES_LATENCY-2:0], vld_q};
    wr_en     = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_base_d = rd_base_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    // Clear wins over a same-cycle capture; a request accepted this cycle lives on in vld_q.
    if (clear_i) begin
      tag_d     = '0;
      wr_ptr_d  = '0;
      rd_base_d = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
    end else if (capture) begin
      if (!full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (mode == MODE_RING) begin
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + AW'(1);
          rd_base_d = rd_base_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= '0;
      key_q      <= '0;
      vld_q      <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_base_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (in_valid_i) begin
        state_q <= in_state_i;
        key_q   <= in_key_i;
      end
      vld_q      <= in_valid_i;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_base_q  <= rd_base_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_en_i;
    end
  end

  aes_capture_buffer_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(aes_out_i),
    .re_i   (rd_en_i),
    .raddr_i(raddr),
    .rdata_o(rd_data_o)
  );

  assign aes_state_o = state_q;
  assign aes_key_o   = key_q;
  assign rd_valid_o  = rd_valid_q;
  assign count_o     = count_q;
  assign full_o      = full;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_aes_capture_buffer.sv
// Bench for aes_capture_buffer: behavioural AES-128 core model plus a queue-based buffer model.
module tb_aes_capture_buffer;
  import aes_cap_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 21;
  localparam int unsigned AW    = 4;

  logic          clk, rst;
  logic          in_valid, mode, clear, rd_en;
  logic [127:0]  in_state, in_key, aes_state, aes_key, aes_out, rd_data;
  logic [AW-1:0] rd_addr;
  logic          rd_valid, full, overflow;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]   sbox [256];
  logic [127:0] core_pipe [LAT];
  logic [127:0] results [$];
  logic [127:0] model_q [$];

  aes_capture_buffer #(
    .WIDTH(128),
    .DEPTH(DEPTH),
    .AES_LATENCY(LAT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_state_i (in_state),
    .in_key_i   (in_key),
    .aes_state_o(aes_state),
    .aes_key_o  (aes_key),
    .aes_out_i  (aes_out),
    .mode_i     (mode),
    .clear_i    (clear),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .count_o    (count),
    .full_o     (full),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} >> (8 - k);
    return d[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] exp_t [256];
    int         log_t [256];
    logic [7:0] p, inv;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // Core model: aes_out reflects the core inputs as they were LAT cycles earlier.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= aes_enc(aes_state, aes_key);
  end
  assign aes_out = core_pipe[LAT-1];

  // ---------------- bench helpers ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_vec(input logic [127:0] pt, input logic [127:0] k, input logic with_clr);
    in_valid = 1'b1;
    in_state = pt;
    in_key   = k;
    clear    = with_clr;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    if (with_clr) results.delete();
    results.push_back(aes_enc(pt, k));
  endtask

  task automatic issue_rand(input logic with_clr);
    issue_vec({$urandom(), $urandom(), $urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()}, with_clr);
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    results.delete();
  endtask

  task automatic read_word(input int addr, output logic [127:0] data);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_en = 1'b0;
    check_eq($sformatf("rd_valid[%0d]", addr), 128'(rd_valid), 128'(1));
    data = rd_data;
  endtask

  // Buffer contents implied by the accepted results and the mode.
  task automatic build_model();
    model_q.delete();
    foreach (results[i]) begin
      if (model_q.size() < DEPTH) begin
        model_q.push_back(results[i]);
      end else if (mode) begin
        void'(model_q.pop_front());
        model_q.push_back(results[i]);
      end
    end
  endtask

  task automatic check_buffer(input string tag);
    logic [127:0] d;
    build_model();
    check_eq({tag, " count"}, 128'(count), 128'(model_q.size()));
    check_eq({tag, " full"}, 128'(full), 128'(model_q.size() == DEPTH));
    check_eq({tag, " overflow"}, 128'(overflow), 128'(results.size() > DEPTH));
    foreach (model_q[i]) begin
      read_word(i, d);
      check_eq($sformatf("%s data[%0d]", tag, i), d, model_q[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] d, old_oldest;
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_key = '0;
    mode = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    build_sbox();
    tick(2);
    check_eq("reset count", 128'(count), 128'(0));
    check_eq("reset full", 128'(full), 128'(0));
    check_eq("reset overflow", 128'(overflow), 128'(0));
    check_eq("reset rd_valid", 128'(rd_valid), 128'(0));
    check_eq("reset rd_data", rd_data, 128'(0));
    check_eq("reset aes_state", aes_state, 128'(0));
    rst = 1'b0;
    tick();

    // FIPS-197 vector and exact capture latency
    issue_vec(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    check_eq("fips aes_state", aes_state, 128'h00112233445566778899aabbccddeeff);
    check_eq("fips aes_key", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    tick(21);
    check_eq("fips count before latency", 128'(count), 128'(0));
    tick();
    check_eq("fips count", 128'(count), 128'(1));
    read_word(0, d);
    check_eq("fips ciphertext", d, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Back-to-back fill
    clear_buf();
    for (int i = 0; i < DEPTH; i++) issue_rand(1'b0);
    tick(25);
    check_buffer("b2b");

    // ONESHOT overflow
    clear_buf();
    mode = 1'b0;
    for (int i = 0; i < 18; i++) issue_rand(1'b0);
    tick(25);
    check_buffer("oneshot");

    // RING wrap, then a read colliding with the capture write returns the old word
    clear_buf();
    mode = 1'b1;
    for (int i = 0; i < 18; i++) issue_rand(1'b0);
    tick(25);
    check_buffer("ring");
    build_model();
    old_oldest = model_q[0];
    issue_rand(1'b0);
    tick(21);
    rd_en   = 1'b1;
    rd_addr = '0;
    tick();
    rd_en = 1'b0;
    check_eq("collision read old", rd_data, old_oldest);
    tick(3);
    check_buffer("ring after collision");

    // Randomised gaps and modes
    for (int it = 0; it < 3; it++) begin
      clear_buf();
      mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(5, 30)); i++) begin
        issue_rand(1'b0);
        tick(int'($urandom_range(0, 3)));
      end
      tick(25);
      check_buffer($sformatf("rand%0d", it));
    end

    // Clear with requests in flight; request issued alongside clear survives
    clear_buf();
    mode = 1'b0;
    for (int i = 0; i < 3; i++) issue_rand(1'b0);
    tick(5);
    clear_buf();
    tick(30);
    check_eq("clear inflight count", 128'(count), 128'(0));
    issue_rand(1'b0);
    issue_rand(1'b1);
    tick(25);
    check_buffer("clear with req");

    // Reset mid-run
    clear_buf();
    for (int i = 0; i < 4; i++) issue_rand(1'b0);
    tick(9);
    read_word(0, d);
    rst = 1'b1;
    #1;
    check_eq("midrst aes_state", aes_state, 128'(0));
    check_eq("midrst aes_key", aes_key, 128'(0));
    check_eq("midrst rd_valid", 128'(rd_valid), 128'(0));
    check_eq("midrst rd_data", rd_data, 128'(0));
    check_eq("midrst count", 128'(count), 128'(0));
    tick(2);
    rst = 1'b0;
    results.delete();
    tick(30);
    check_eq("post rst count", 128'(count), 128'(0));
    check_eq("post rst overflow", 128'(overflow), 128'(0));
    issue_rand(1'b0);
    tick(25);
    check_buffer("post rst fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
